// File: rtl/conv_tile_sched.sv
// Layer scheduler for CONV_ACC: walks the row tiles of one conv layer, drives the
// source read addresses and merges backpressure into the accelerator stall.
// Optional SCHED_PERF_EN adds RUN-cycle and stall-cycle performance counters.
module conv_tile_sched #(
  parameter int ADDR_W = 16,
  parameter int TILE_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              layer_start,
  input  logic              abort,
  input  logic [31:0]       cfg_ci,
  input  logic [31:0]       cfg_co,
  input  logic [TILE_W-1:0] cfg_tiles,
  input  logic [ADDR_W-1:0] cfg_ifm_base,
  input  logic [ADDR_W-1:0] cfg_ifm_stride,
  input  logic [ADDR_W-1:0] cfg_wgt_base,
  input  logic              ifm_vld,
  input  logic              wgt_vld,
  input  logic              ofm_rdy,
  input  logic              acc_ifm_read,
  input  logic              acc_wgt_read,
  input  logic              acc_end_op,
  output logic              acc_start_conv,
  output logic [31:0]       acc_cfg_ci,
  output logic [31:0]       acc_cfg_co,
  output logic [31:0]       acc_tile_num,
  output logic              acc_stall,
  output logic [ADDR_W-1:0] ifm_addr,
  output logic [ADDR_W-1:0] wgt_addr,
  output logic              busy,
  output logic              layer_done
`ifdef SCHED_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_run_cyc,
  output logic [CNT_W-1:0]  perf_stall_cyc
`endif
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] ARM   = 3'd3;
  localparam logic [2:0] RUN   = 3'd4;
  localparam logic [2:0] NEXT  = 3'd5;
  localparam logic [2:0] DONE  = 3'd6;

  logic [2:0]        state_reg, state_next;
  logic [31:0]       ci_reg, co_reg;
  logic [TILE_W-1:0] tiles_reg, tile_idx_reg;
  logic [ADDR_W-1:0] ifm_base_reg, ifm_stride_reg, wgt_base_reg;
  logic [ADDR_W-1:0] ifm_addr_reg, wgt_addr_reg;
  logic [ADDR_W-1:0] tile_ofs;
  logic              in_run, kill, accept;

  assign in_run = (state_reg == RUN);
  assign kill   = abort && (state_reg != IDLE);
  assign accept = layer_start && (state_reg == IDLE);
  // Only the low ADDR_W bits of the tile offset matter since addresses wrap.
  assign tile_ofs = ADDR_W'(tile_idx_reg) * ifm_stride_reg;

  assign acc_stall      = in_run && (!ifm_vld || !wgt_vld || !ofm_rdy);
  assign acc_start_conv = (state_reg == START);
  assign layer_done     = (state_reg == DONE);
  assign busy           = (state_reg != IDLE);
  assign acc_cfg_ci     = ci_reg;
  assign acc_cfg_co     = co_reg;
  assign acc_tile_num   = 32'(tile_idx_reg);
  assign ifm_addr       = ifm_addr_reg;
  assign wgt_addr       = wgt_addr_reg;

  always_comb begin
    state_next = state_reg;
    if (kill) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (layer_start) state_next = LOAD;
        LOAD:    state_next = (tiles_reg == '0) ? DONE : START;
        START:   state_next = ARM;
        ARM:     if (!acc_end_op) state_next = RUN;
        RUN:     if (acc_end_op) state_next = NEXT;
        NEXT:    state_next = (tile_idx_reg + TILE_W'(1) == tiles_reg) ? DONE : START;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      ci_reg         <= '0;
      co_reg         <= '0;
      tiles_reg      <= '0;
      ifm_base_reg   <= '0;
      ifm_stride_reg <= '0;
      wgt_base_reg   <= '0;
      tile_idx_reg   <= '0;
      ifm_addr_reg   <= '0;
      wgt_addr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        ci_reg         <= cfg_ci;
        co_reg         <= cfg_co;
        tiles_reg      <= cfg_tiles;
        ifm_base_reg   <= cfg_ifm_base;
        ifm_stride_reg <= cfg_ifm_stride;
        wgt_base_reg   <= cfg_wgt_base;
        tile_idx_reg   <= '0;
      end
      if (kill) begin
        tile_idx_reg <= '0;
        ifm_addr_reg <= '0;
        wgt_addr_reg <= '0;
      end else begin
        case (state_reg)
          START: begin
            ifm_addr_reg <= ifm_base_reg + tile_ofs;
            wgt_addr_reg <= wgt_base_reg;
          end
          RUN: begin
            if (acc_ifm_read && !acc_stall) ifm_addr_reg <= ifm_addr_reg + ADDR_W'(1);
            if (acc_wgt_read && !acc_stall) wgt_addr_reg <= wgt_addr_reg + ADDR_W'(1);
          end
          NEXT:    tile_idx_reg <= tile_idx_reg + TILE_W'(1);
          default: ;
        endcase
      end
    end
  end

`ifdef SCHED_PERF_EN
  logic [CNT_W-1:0] perf_run_reg, perf_stall_reg;

  // Counters saturate rather than wrap so long layers never report a small count.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      perf_run_reg   <= '0;
      perf_stall_reg <= '0;
    end else if (in_run) begin
      if (!(&perf_run_reg)) perf_run_reg <= perf_run_reg + CNT_W'(1);
      if (acc_stall && !(&perf_stall_reg)) perf_stall_reg <= perf_stall_reg + CNT_W'(1);
    end
  end

  assign perf_run_cyc   = perf_run_reg;
  assign perf_stall_cyc = perf_stall_reg;
`endif

endmodule

// File: tb/tb_conv_tile_sched.sv
// Scoreboard bench for conv_tile_sched: expected per-tile start records are queued
// when a layer is launched and matched against each acc_start_conv pulse.
module tb_conv_tile_sched;
  localparam int ADDR_W = 16;
  localparam int TILE_W = 16;
  localparam int CNT_W  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic layer_start = 0, abort = 0;
  logic [31:0] cfg_ci = 0, cfg_co = 0;
  logic [TILE_W-1:0] cfg_tiles = 0;
  logic [ADDR_W-1:0] cfg_ifm_base = 0, cfg_ifm_stride = 0, cfg_wgt_base = 0;
  logic ifm_vld = 1, wgt_vld = 1, ofm_rdy = 1;
  logic acc_ifm_read = 0, acc_wgt_read = 0, acc_end_op = 0;
  logic acc_start_conv, acc_stall, busy, layer_done;
  logic [31:0] acc_cfg_ci, acc_cfg_co, acc_tile_num;
  logic [ADDR_W-1:0] ifm_addr, wgt_addr;
`ifdef SCHED_PERF_EN
  logic [CNT_W-1:0] perf_run_cyc, perf_stall_cyc;
`endif

  always #5 clk = ~clk;

  conv_tile_sched #(.ADDR_W(ADDR_W), .TILE_W(TILE_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .layer_start(layer_start), .abort(abort),
    .cfg_ci(cfg_ci), .cfg_co(cfg_co), .cfg_tiles(cfg_tiles),
    .cfg_ifm_base(cfg_ifm_base), .cfg_ifm_stride(cfg_ifm_stride), .cfg_wgt_base(cfg_wgt_base),
    .ifm_vld(ifm_vld), .wgt_vld(wgt_vld), .ofm_rdy(ofm_rdy),
    .acc_ifm_read(acc_ifm_read), .acc_wgt_read(acc_wgt_read), .acc_end_op(acc_end_op),
    .acc_start_conv(acc_start_conv), .acc_cfg_ci(acc_cfg_ci), .acc_cfg_co(acc_cfg_co),
    .acc_tile_num(acc_tile_num), .acc_stall(acc_stall), .ifm_addr(ifm_addr),
    .wgt_addr(wgt_addr), .busy(busy), .layer_done(layer_done)
`ifdef SCHED_PERF_EN
    , .perf_run_cyc(perf_run_cyc), .perf_stall_cyc(perf_stall_cyc)
`endif
  );

  typedef struct {
    logic [31:0]       tile;
    logic [ADDR_W-1:0] ifm;
    logic [ADDR_W-1:0] wgt;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   addr_pend = 0;
  int   n_tests = 0, n_fail = 0;
  int   start_cnt = 0, done_cnt = 0;
  int   s0, d0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expected record per start pulse; addresses land one cycle later.
  always @(negedge clk) begin
    if (!rst) begin
      if (addr_pend) begin
        check("ifm_addr_at_start", ifm_addr, cur.ifm);
        check("wgt_addr_at_start", wgt_addr, cur.wgt);
        addr_pend = 0;
      end
      if (acc_start_conv) begin
        start_cnt++;
        $display("[TB] start tile=%0d", acc_tile_num);
        if (exp_q.size() == 0) begin
          check("unexpected_start", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          check("tile_num", acc_tile_num, cur.tile);
          addr_pend = 1;
        end
      end
      if (layer_done) begin
        done_cnt++;
        $display("[TB] layer_done");
      end
    end
  end

  task automatic start_layer(input int tiles, input logic [ADDR_W-1:0] base,
                             input logic [ADDR_W-1:0] stride, input logic [ADDR_W-1:0] wgt,
                             input logic [31:0] ci, input logic [31:0] co);
    exp_t e;
    logic [ADDR_W-1:0] a;
    a = base;
    for (int t = 0; t < tiles; t++) begin
      e.tile = 32'(t);
      e.ifm  = a;
      e.wgt  = wgt;
      exp_q.push_back(e);
      a = a + stride;
    end
    cfg_tiles = TILE_W'(tiles); cfg_ifm_base = base; cfg_ifm_stride = stride;
    cfg_wgt_base = wgt; cfg_ci = ci; cfg_co = co;
    layer_start = 1;
    tick();
    layer_start = 0;
  endtask

  task automatic wait_start();
    int n = 0;
    while (!acc_start_conv && n < 200) begin tick(); n++; end
    check("start_timeout", acc_start_conv, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!layer_done && n < 200) begin tick(); n++; end
    check("done_timeout", layer_done, 1);
  endtask

  task automatic do_tile(input int run_len);
    wait_start();
    tick();                 // ARM
    tick();                 // RUN
    repeat (run_len) tick();
    acc_end_op = 1;
    tick();                 // NEXT
    acc_end_op = 0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) tick();
    check("rst_start", acc_start_conv, 0);
    check("rst_busy", busy, 0);
    check("rst_done", layer_done, 0);
    check("rst_stall", acc_stall, 0);
    check("rst_ifm", ifm_addr, 0);
    check("rst_wgt", wgt_addr, 0);
    check("rst_tile", acc_tile_num, 0);
    check("rst_ci", acc_cfg_ci, 0);
    rst = 0;
    tick();

    // Single tile, latency check
    s0 = start_cnt; d0 = done_cnt;
    start_layer(1, 16'h0100, 16'h0040, 16'h0011, 32'd3, 32'd8);
    check("busy_after_start", busy, 1);
    tick();
    check("start_latency", acc_start_conv, 1);
    do_tile(50);
    wait_done();
    tick();
    check("single_done_cnt", done_cnt - d0, 1);
    check("single_start_cnt", start_cnt - s0, 1);
    check("single_idle", busy, 0);
    check("cfg_ci", acc_cfg_ci, 32'd3);
    check("cfg_co", acc_cfg_co, 32'd8);

    // Multi-tile
    s0 = start_cnt; d0 = done_cnt;
    start_layer(3, 16'h0100, 16'h0040, 16'h0055, 32'd4, 32'd4);
    repeat (3) do_tile(10);
    wait_done();
    tick();
    check("multi_start_cnt", start_cnt - s0, 3);
    check("multi_done_cnt", done_cnt - d0, 1);

    // Backpressure on ifm source
    start_layer(1, 16'h0200, 16'h0000, 16'h0080, 32'd1, 32'd1);
    wait_start();
    tick();
    ifm_vld = 0;
    #1 check("stall_in_arm", acc_stall, 0);
    ifm_vld = 1;
    tick();
    acc_ifm_read = 1; acc_wgt_read = 1; ifm_vld = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_stall", acc_stall, 1);
      check("bp_ifm_hold", ifm_addr, 16'h0200);
      check("bp_wgt_hold", wgt_addr, 16'h0080);
      tick();
    end
    ifm_vld = 1;
    #1 check("bp_release", acc_stall, 0);
    repeat (3) tick();
    check("bp_ifm_resume", ifm_addr, 16'h0203);
    check("bp_wgt_resume", wgt_addr, 16'h0083);
    acc_ifm_read = 0; acc_wgt_read = 0;
    ofm_rdy = 0;
    #1 check("ofm_stall", acc_stall, 1);
    ofm_rdy = 1;
    acc_end_op = 1;
    tick();
    acc_end_op = 0;
    wait_done();
`ifdef SCHED_PERF_EN
    check("perf_stall_bp", perf_stall_cyc, 5);
`endif
    tick();

    // Stale end_op held through START
    s0 = start_cnt; d0 = done_cnt;
    acc_end_op = 1;
    start_layer(2, 16'h0400, 16'h0020, 16'h0009, 32'd2, 32'd2);
    wait_start();
    repeat (5) tick();
    check("stale_no_next", start_cnt - s0, 1);
    check("stale_busy", busy, 1);
    acc_end_op = 0;
    tick();
    repeat (5) tick();
    acc_end_op = 1;
    tick();
    acc_end_op = 0;
    do_tile(5);
    wait_done();
    tick();
    check("stale_start_cnt", start_cnt - s0, 2);
    check("stale_done_cnt", done_cnt - d0, 1);

    // Zero tiles
    s0 = start_cnt; d0 = done_cnt;
    start_layer(0, 16'h0000, 16'h0000, 16'h0000, 32'd7, 32'd7);
    tick();
    check("zero_done_latency", layer_done, 1);
    tick();
    check("zero_no_start", start_cnt - s0, 0);
    check("zero_done_cnt", done_cnt - d0, 1);

    // layer_start while busy is ignored
    s0 = start_cnt; d0 = done_cnt;
    start_layer(1, 16'h0600, 16'h0000, 16'h0001, 32'd5, 32'd5);
    wait_start();
    tick(); tick();
    cfg_ci = 32'd9; cfg_tiles = 16'd3;
    layer_start = 1;
    tick();
    layer_start = 0;
    check("ign_cfg_ci", acc_cfg_ci, 32'd5);
    repeat (3) tick();
    acc_end_op = 1;
    tick();
    acc_end_op = 0;
    wait_done();
    repeat (6) tick();
    check("ign_start_cnt", start_cnt - s0, 1);
    check("ign_done_cnt", done_cnt - d0, 1);
    check("ign_idle", busy, 0);

    // Abort in RUN at tile 1 of 4
    s0 = start_cnt; d0 = done_cnt;
    start_layer(4, 16'h0300, 16'h0010, 16'h0077, 32'd6, 32'd6);
    do_tile(3);
    wait_start();
    tick(); tick();
    ifm_vld = 0;
    tick(); tick();
    ifm_vld = 1;
    acc_ifm_read = 1;
    abort = 1;
    tick();
    abort = 0;
    acc_ifm_read = 0;
    check("abort_busy", busy, 0);
    check("abort_stall", acc_stall, 0);
    check("abort_start", acc_start_conv, 0);
    check("abort_tile", acc_tile_num, 0);
    check("abort_ifm", ifm_addr, 0);
    check("abort_wgt", wgt_addr, 0);
    repeat (5) tick();
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_start_cnt", start_cnt - s0, 2);
`ifdef SCHED_PERF_EN
    check("perf_stall_abort", perf_stall_cyc, 2);
`endif
    exp_q.delete();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
